mem_1kb_copier: RTL and testbench

Bus-initiator block-copy engine that drives the word-addressed read/write port of the 1 KB byte-organised data memory (256 × 32-bit words) from the other side. On a `start` pulse it copies `len` consecutive words from `src_addr` to `dst_addr`. Each word uses one read strobe, then one write strobe, and waits for the memory's `rd_done`/`wr_done` acknowledge before continuing. It sits between the processor control logic and the data memory, and has a per-access acknowledge timeout.

---
 rtl/mem_1kb_pkg.sv | 17 +
 rtl/mem_1kb_ack_timer.sv | 37 +++
 rtl/mem_1kb_copier.sv | 190 +++++++++++++++++++
 tb/tb_mem_1kb_copier.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_1kb_pkg.sv
// Shared constants and FSM state type for the 1 KB data memory and its block-copy engine.
package mem_1kb_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_WORDS  = 256;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FIN
    } copier_state_e;

endpackage

// File: rtl/mem_1kb_ack_timer.sv
// Per-wait acknowledge timer: counts cycles spent in a WAIT state and flags expiry at TIMEOUT.
module mem_1kb_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Clear preloads 1 so the count equals the number of WAIT cycles elapsed, including the current one.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd1;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q >= LIMIT);

endmodule

// File: rtl/mem_1kb_copier.sv
// Block-copy bus initiator for the 1 KB data memory: read one word, write it, repeat len times.
// Optional running checksum of copied words is enabled by defining MEM_1KB_COPIER_CHECKSUM_EN.
module mem_1kb_copier
    import mem_1kb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] src_addr,
    input  logic [MEM_ADDR_W-1:0] dst_addr,
    input  logic [8:0]            len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [8:0]            words_copied,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_read_addr,
    output logic [MEM_ADDR_W-1:0] mem_write_addr,
    output logic [MEM_DATA_W-1:0] mem_wr_data,
    input  logic [MEM_DATA_W-1:0] mem_rd_data,
    input  logic                  mem_rd_done,
    input  logic                  mem_wr_done
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
    ,
    output logic [MEM_DATA_W-1:0] checksum
`endif
);

    copier_state_e state_q, state_d;

    logic [MEM_ADDR_W-1:0] src_q, src_d;
    logic [MEM_ADDR_W-1:0] dst_q, dst_d;
    logic [8:0]            len_q, len_d;
    logic [8:0]            words_q, words_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [MEM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [MEM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [MEM_DATA_W-1:0] wr_data_q, wr_data_d;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
    logic [MEM_DATA_W-1:0] checksum_q, checksum_d;
`endif

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign timer_clear  = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign timer_enable = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    mem_1kb_ack_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_ack_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        words_d   = words_q;
        error_d   = error_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    words_d = 9'd0;
                    error_d = 1'b0;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    state_d = (len == 9'd0) ? FIN : RD_REQ;
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                // An acknowledge arriving in the expiry cycle still wins over the timeout.
                if (mem_rd_done) begin
                    wr_data_d = mem_rd_data;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
                    checksum_d = checksum_q + mem_rd_data;
`endif
                    state_d   = WR_REQ;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (mem_wr_done) begin
                    words_d = words_q + 9'd1;
                    src_d   = src_q + 8'd1;
                    dst_d   = dst_q + 8'd1;
                    state_d = ((words_q + 9'd1) == len_q) ? FIN : RD_REQ;
                end else if (timer_expired) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so that every port comes straight from a flop.
        busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
                 (state_d == WR_REQ) || (state_d == WR_WAIT);
        done_d = (state_d == FIN);
        rd_d   = (state_d == RD_REQ);
        wr_d   = (state_d == WR_REQ);
        if (rd_d) begin
            rd_addr_d = src_d;
        end
        if (wr_d) begin
            wr_addr_d = dst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            words_q   <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            words_q   <= words_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_copied   = words_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_read_addr  = rd_addr_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_wr_data    = wr_data_q;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
    assign checksum       = checksum_q;
`endif

endmodule

// File: tb/tb_mem_1kb_copier.sv
// Self-checking bench for mem_1kb_copier against a 1-cycle-acknowledge memory and a word-level copy model.
module tb_mem_1kb_copier;
    import mem_1kb_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_copied;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_read_addr;
    logic [7:0]  mem_write_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = 32'd0;
    logic        mem_rd_done = 1'b0;
    logic        mem_wr_done = 1'b0;
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] exp_wd  [MEM_WORDS];
    logic        rd_ack_en;
    logic        wr_ack_en;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int total = 0;
    int bad   = 0;

    mem_1kb_copier #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_copied  (words_copied),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_read_addr (mem_read_addr),
        .mem_write_addr(mem_write_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_done   (mem_rd_done),
        .mem_wr_done   (mem_wr_done)
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory with single-cycle acknowledge; acks can be suppressed to provoke timeouts.
    always @(posedge clk) begin
        mem_rd_done <= 1'b0;
        mem_wr_done <= 1'b0;
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (mem_read && rd_ack_en) begin
            mem_rd_data <= mem[mem_read_addr];
            mem_rd_done <= 1'b1;
        end
        if (mem_write && wr_ack_en) begin
            mem[mem_write_addr] <= mem_wr_data;
            mem_wr_done <= 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic syncMem();
        for (int i = 0; i < MEM_WORDS; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_addr = 8'(i);
            pl_data = ref_mem[i];
        end
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic pulseStart(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = l;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_done"},  32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_words"}, 32'(words_copied), 32'd0);
        checkOutput({tag, "_rd"},    32'(mem_read), 32'd0);
        checkOutput({tag, "_wr"},    32'(mem_write), 32'd0);
        checkOutput({tag, "_raddr"}, 32'(mem_read_addr), 32'd0);
        checkOutput({tag, "_waddr"}, 32'(mem_write_addr), 32'd0);
        checkOutput({tag, "_wdata"}, mem_wr_data, 32'd0);
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
        checkOutput({tag, "_csum"},  checksum, 32'd0);
`endif
    endtask

    // Full copy: model the forward word-by-word copy, then watch every cycle until done.
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        logic [31:0] sum;
        logic [7:0]  ra;
        logic [7:0]  wa;
        int cyc, busy_cnt, rd_cnt, wr_cnt, diffs;
        bit got_done;
        sum = 32'd0;
        for (int i = 0; i < int'(l); i++) begin
            ra = s + 8'(i);
            wa = d + 8'(i);
            exp_wd[i]   = ref_mem[ra];
            ref_mem[wa] = exp_wd[i];
            sum         = sum + exp_wd[i];
        end
        pulseStart(s, d, l);
        cyc = 0; busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; got_done = 1'b0;
        while (!got_done && cyc < 4 * int'(l) + 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (mem_read && mem_write) checkOutput("strobe_excl", 32'd1, 32'd0);
            if (mem_read) begin
                ra = s + 8'(rd_cnt);
                checkOutput("rd_addr", 32'(mem_read_addr), 32'(ra));
                rd_cnt++;
            end
            if (mem_write) begin
                wa = d + 8'(wr_cnt);
                checkOutput("wr_addr", 32'(mem_write_addr), 32'(wa));
                if (wr_cnt < MEM_WORDS) checkOutput("wr_data", mem_wr_data, exp_wd[wr_cnt]);
                wr_cnt++;
            end
            if (done) begin
                got_done = 1'b1;
                checkOutput("busy_at_done", 32'(busy), 32'd0);
            end
        end
        checkOutput("done_cycle", 32'(cyc), 32'(4 * int'(l) + 1));
        checkOutput("busy_cycles", 32'(busy_cnt), 32'(4 * int'(l)));
        checkOutput("read_count", 32'(rd_cnt), 32'(l));
        checkOutput("write_count", 32'(wr_cnt), 32'(l));
        checkOutput("words_copied", 32'(words_copied), 32'(l));
        checkOutput("error_clear", 32'(error), 32'd0);
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        checkOutput("mem_image", 32'(diffs), 32'd0);
`ifdef MEM_1KB_COPIER_CHECKSUM_EN
        checkOutput("checksum", checksum, sum);
`endif
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
    endtask

    // Suppress one kind of acknowledge and expect an error completion TIMEOUT+1 cycles after the strobe.
    task automatic runTimeout(input bit on_read);
        int cyc, first, wr_cnt;
        bit got_done;
        if (on_read) rd_ack_en = 1'b0;
        else         wr_ack_en = 1'b0;
        pulseStart(8'h10, 8'h80, 9'd3);
        cyc = 0; first = -1000; wr_cnt = 0; got_done = 1'b0;
        while (!got_done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (mem_write) wr_cnt++;
            if (first < 0 && ((on_read && mem_read) || (!on_read && mem_write))) first = cyc;
            if (done) got_done = 1'b1;
        end
        checkOutput(on_read ? "rd_timeout_delay" : "wr_timeout_delay", 32'(cyc - first), 32'(TIMEOUT + 1));
        checkOutput("timeout_error", 32'(error), 32'd1);
        checkOutput("timeout_words", 32'(words_copied), 32'd0);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        if (on_read) checkOutput("rd_timeout_no_write", 32'(wr_cnt), 32'd0);
        @(negedge clk);
        checkOutput("error_sticky", 32'(error), 32'd1);
        rd_ack_en = 1'b1;
        wr_ack_en = 1'b1;
        applyStimulus(8'h10, 8'h80, 9'd0);
    endtask

    // Reset during WR_WAIT of the second word; a start pulse while busy must not disturb the copy.
    task automatic runResetMidCopy();
        int cyc, rd_cnt, wr_cnt;
        logic [7:0] ra;
        pulseStart(8'h10, 8'h40, 9'd4);
        cyc = 0; rd_cnt = 0; wr_cnt = 0;
        while (wr_cnt < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 1);
            if (cyc == 1) begin
                src_addr = 8'h77;
                len      = 9'd0;
            end
            if (mem_read) begin
                ra = 8'h10 + 8'(rd_cnt);
                checkOutput("busy_start_ignored", 32'(mem_read_addr), 32'(ra));
                rd_cnt++;
            end
            if (mem_write) wr_cnt++;
        end
        start = 1'b0;
        checkOutput("second_write_seen", 32'(wr_cnt), 32'd2);
        @(negedge clk);
        checkOutput("wr_wait_busy", 32'(busy), 32'd1);
        checkOutput("wr_wait_words", 32'(words_copied), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = 8'd0; dst_addr = 8'd0; len = 9'd0;
        rd_ack_en = 1'b1; wr_ack_en = 1'b1; pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        ref_mem[8'h10] = 32'h11111111;
        ref_mem[8'h11] = 32'h22222222;
        ref_mem[8'h12] = 32'h33333333;
        ref_mem[8'h13] = 32'h44444444;
        syncMem();
        $display("[TB] directed copy 0x10 -> 0x80, len 4");
        applyStimulus(8'h10, 8'h80, 9'd4);
        $display("[TB] zero-length copy");
        applyStimulus(8'h20, 8'h30, 9'd0);
        $display("[TB] wrapping overlapping copy 0xFE -> 0x01, len 4");
        applyStimulus(8'hFE, 8'h01, 9'd4);

        $display("[TB] write and read acknowledge timeouts");
        runTimeout(1'b0);
        runTimeout(1'b1);

        $display("[TB] reset in the middle of a copy");
        runResetMidCopy();

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
            syncMem();
            applyStimulus(8'($urandom), 8'($urandom), 9'($urandom_range(1, 24)));
        end

        $display("[TB] whole-memory self copy");
        applyStimulus(8'h00, 8'h00, 9'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
